// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared memory port signals seen by mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding caches and memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the I-cache and D-cache,
// with a saturating count of contended arbitration cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_arbiter_if.slave         bus,
    output logic [CNT_WIDTH-1:0] conflict_count
);
    typedef enum logic [1:0] {StIdle, StServeI, StServeD, StRecover} state_t;

    localparam logic [CNT_WIDTH-1:0] CntOne = 1;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic i_req, d_req, serve_i, serve_d, serving, i_resp, d_resp;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_req && d_req && !(&cnt_q)) begin
                    cnt_d = cnt_q + CntOne;
                end
                // On a tie the side not served last wins; a write takes precedence over a read.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d = StServeD;
                    addr_d  = bus.d_address;
                    write_d = bus.d_write;
                    wdata_d = bus.d_write ? bus.d_wdata : '0;
                end else if (i_req) begin
                    state_d = StServeI;
                    addr_d  = bus.i_address;
                    write_d = 1'b0;
                    wdata_d = '0;
                end
            end
            StServeI, StServeD: begin
                if (bus.mem_resp) begin
                    state_d  = StRecover;
                    last_d_d = (state_q == StServeD);
                end
            end
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            last_d_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign serve_i = (state_q == StServeI);
    assign serve_d = (state_q == StServeD);
    assign serving = serve_i | serve_d;
    assign i_resp  = serve_i & bus.mem_resp;
    assign d_resp  = serve_d & bus.mem_resp;

    assign bus.mem_read    = serving & ~write_q;
    assign bus.mem_write   = serving & write_q;
    assign bus.mem_address = serving ? addr_q : '0;
    assign bus.mem_wdata   = serving ? wdata_q : '0;

    // Read data is only visible in the response cycle of the winner.
    assign bus.i_resp  = i_resp;
    assign bus.d_resp  = d_resp;
    assign bus.i_rdata = i_resp ? bus.mem_rdata : '0;
    assign bus.d_rdata = (d_resp && !write_q) ? bus.mem_rdata : '0;

    assign conflict_count = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: cache/memory drivers issue requests, a negedge
// monitor predicts each grant and response from the arbitration rules and compares.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
        int            t;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus4 ();

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .conflict_count(cnt)
    );
    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .conflict_count(cnt4)
    );

    assign bus4.i_read    = bus.i_read;
    assign bus4.i_address = bus.i_address;
    assign bus4.d_read    = bus.d_read;
    assign bus4.d_write   = bus.d_write;
    assign bus4.d_address = bus.d_address;
    assign bus4.d_wdata   = bus.d_wdata;
    assign bus4.mem_rdata = bus.mem_rdata;
    assign bus4.mem_resp  = bus.mem_resp;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    req_t i_q[$];
    req_t d_q[$];
    bit   glog[$];

    // monitor-side model
    bit          in_txn, cur_d, last_d, i_done, d_done;
    req_t        cur;
    int          rec_left;
    int unsigned cnt_m, cnt4_m;

    // driver-side state
    bit i_busy, d_busy, mem_busy, hold_mem, drop_en;
    int lat, p_i, p_d, d_op_force;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        else passed++;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_strobe", {bus.mem_read, bus.mem_write}, 0);
            chk("rst_resp", {bus.i_resp, bus.d_resp}, 0);
            chk("rst_addr", bus.mem_address, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
            chk("rst_count", cnt, 0);
            chk("rst_count4", cnt4, 0);
            in_txn = 0; last_d = 0; rec_left = 0; cnt_m = 0; cnt4_m = 0;
            i_done = 0; d_done = 0;
            i_q.delete(); d_q.delete(); glog.delete();
        end else begin
            automatic bit strobe = bus.mem_read | bus.mem_write;
            chk("mutex", bus.mem_read & bus.mem_write, 0);
            if (rec_left > 0) begin
                chk("recover_quiet", strobe, 0);
                rec_left--;
            end else if (!in_txn) begin
                automatic bit ip = (i_q.size() > 0) && (i_q[0].t < cyc);
                automatic bit dp = (d_q.size() > 0) && (d_q[0].t < cyc);
                if (strobe) begin
                    chk("grant_has_request", ip | dp, 1);
                    if (ip || dp) begin
                        automatic bit win_d = dp && (!ip || !last_d);
                        if (ip && dp) begin
                            if (cnt_m < 65535) cnt_m++;
                            if (cnt4_m < 15) cnt4_m++;
                        end
                        cur = win_d ? d_q.pop_front() : i_q.pop_front();
                        cur_d = win_d;
                        in_txn = 1;
                        glog.push_back(win_d);
                        chk("grant_addr", bus.mem_address, cur.addr);
                        chk("grant_op", bus.mem_write, cur.wr);
                        if (cur.wr) chk("grant_wdata", bus.mem_wdata, cur.wdata);
                    end
                end else if (ip || dp) begin
                    chk("grant_latency", strobe, 1);
                end
            end else begin
                chk("hold_strobe", strobe, 1);
                chk("hold_addr", bus.mem_address, cur.addr);
                chk("hold_op", bus.mem_write, cur.wr);
            end

            if (bus.mem_resp && in_txn) begin
                chk("i_resp", bus.i_resp, !cur_d);
                chk("d_resp", bus.d_resp, cur_d);
                chk("i_rdata", bus.i_rdata, cur_d ? {LW{1'b0}} : bus.mem_rdata);
                chk("d_rdata", bus.d_rdata, (cur_d && !cur.wr) ? bus.mem_rdata : {LW{1'b0}});
                if (cur_d) d_done = 1;
                else i_done = 1;
                last_d = cur_d;
                in_txn = 0;
                rec_left = 2;
            end else begin
                chk("quiet_resp", {bus.i_resp, bus.d_resp}, 0);
                chk("quiet_rdata", bus.i_rdata | bus.d_rdata, 0);
            end
            chk("count", cnt, cnt_m);
            chk("count4", cnt4, cnt4_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_rdata = rand_line();
        if (bus.mem_resp) begin
            bus.mem_resp = 1'b0;
            mem_busy = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (!mem_busy) begin
                mem_busy = 1;
                lat = $urandom_range(0, 3);
            end
            if (!hold_mem) begin
                if (lat == 0) bus.mem_resp = 1'b1;
                else lat--;
            end
        end

        if (i_done) begin
            i_done = 0; i_busy = 0; bus.i_read = 1'b0;
        end else if (i_busy && in_txn && !cur_d) begin
            if ($urandom_range(0, 3) == 0) bus.i_address = AW'($urandom);
            if (drop_en && $urandom_range(0, 3) == 0) bus.i_read = 1'b0;
        end
        if (!i_busy && $urandom_range(1, 100) <= p_i) begin
            automatic req_t e;
            e.addr = AW'($urandom); e.wr = 0; e.wdata = '0; e.t = cyc;
            bus.i_address = e.addr;
            bus.i_read = 1'b1;
            i_busy = 1;
            i_q.push_back(e);
        end

        if (d_done) begin
            d_done = 0; d_busy = 0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        end else if (d_busy && in_txn && cur_d) begin
            if ($urandom_range(0, 3) == 0) bus.d_address = 16'hFFFE;
            if ($urandom_range(0, 3) == 0) bus.d_wdata = rand_line();
            if (drop_en && $urandom_range(0, 3) == 0) begin
                bus.d_read = 1'b0; bus.d_write = 1'b0;
            end
        end
        if (!d_busy && $urandom_range(1, 100) <= p_d) begin
            automatic req_t e;
            automatic int op = (d_op_force >= 0) ? d_op_force : $urandom_range(0, 2);
            bus.d_read  = (op != 1);
            bus.d_write = (op != 0);
            bus.d_address = AW'($urandom);
            bus.d_wdata = rand_line();
            e.addr = bus.d_address; e.wr = (op != 0);
            e.wdata = e.wr ? bus.d_wdata : '0; e.t = cyc;
            d_busy = 1;
            d_q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.mem_resp = 1'b1;
        i_busy = 0; d_busy = 0; mem_busy = 0;
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        i_busy = 0; d_busy = 0; mem_busy = 0; hold_mem = 0; drop_en = 0;
        lat = 0; p_i = 0; p_d = 0; d_op_force = -1;

        // I-cache alone
        do_reset();
        p_i = 100; p_d = 0;
        run(30);
        p_i = 0;
        run(12);

        // continuous contention from reset: strict alternation starting with D
        do_reset();
        p_i = 100; p_d = 100;
        run(250);
        chk("order_len_ok", glog.size() >= 6, 1);
        if (glog.size() >= 6)
            for (int k = 0; k < 6; k++) chk("grant_order", glog[k], (k % 2) == 0);
        chk("sat4", cnt4, 15);
        chk("count_no_wrap", cnt > 16'd15, 1);
        p_i = 0; p_d = 0;
        run(12);

        // random traffic with inputs changing and requests dropped mid-service
        drop_en = 1; p_i = 30; p_d = 30;
        run(600);
        p_i = 0; p_d = 0;
        run(15);

        // reset during a D writeback, then a stray mem_resp
        drop_en = 0; hold_mem = 1; d_op_force = 1; p_d = 100;
        begin
            automatic int budget = 40;
            while (!(in_txn && cur_d && cur.wr) && budget > 0) begin
                step();
                budget--;
            end
            chk("reach_serve_d_write", in_txn && cur_d && cur.wr, 1);
        end
        chk("write_strobe_before_reset", bus.mem_write, 1);
        p_d = 0; d_op_force = -1; hold_mem = 0;
        do_reset();
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        run(3);

        // more random traffic and final drain
        drop_en = 1; p_i = 50; p_d = 40;
        run(400);
        p_i = 0; p_d = 0;
        run(20);
        chk("drained", {in_txn, i_busy, d_busy, 1'b0}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one physical memory port (L2 / pmem, line-granular) between the instruction-cache miss port and the data-cache miss/writeback port of the pipelined LC-3b core.
- Sits below both L1 caches. Latches the winning request, drives the shared port until mem_resp, then routes the response back to the winner only.
- Round-robin arbitration on contention. Includes a saturating contention counter for performance analysis.

Parameters:
- ADDR_WIDTH, 16, byte address width of all address ports.
- LINE_WIDTH, 128, cache line width in bits.
- CNT_WIDTH, 16, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to the I-cache
- i_resp  out  1  I-cache transaction complete, one-cycle pulse
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line writeback request
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache writeback data
- d_rdata  out  LINE_WIDTH  line returned to the D-cache
- d_resp  out  1  D-cache transaction complete, one-cycle pulse
- mem_read  out  1  shared port read strobe
- mem_write  out  1  shared port write strobe
- mem_address  out  ADDR_WIDTH  shared port address
- mem_wdata  out  LINE_WIDTH  shared port write data
- mem_rdata  in  LINE_WIDTH  shared port read data
- mem_resp  in  1  shared port completion
- conflict_count  out  CNT_WIDTH  number of cycles in IDLE with both requesters pending; saturating

Behaviour:
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
  - RECOVER
- Reset (async, immediate):
  - State is IDLE, last_served = I, so D wins the first tie.
  - All outputs are 0. Address and data latches clear to 0. conflict_count = 0.
- Reset mid-transaction: the port strobes drop at once. A mem_resp arriving after reset deasserts is ignored, because no resp is forwarded from IDLE.
- IDLE:
  - Sample the requests. A D request is d_read | d_write.
  - Only I pending: go to SERVE_I.
  - Only D pending: go to SERVE_D.
  - Both pending: grant the requester that is not last_served, and increment conflict_count by 1, saturating at all-ones.
  - On grant, latch the winner's address, the op, and d_wdata into internal registers.
  - The mem_* strobes are not asserted in IDLE.
- SERVE_I / SERVE_D:
  - mem_address, mem_wdata, mem_read and mem_write are driven from the latches. The requester may change its inputs during service without effect.
  - Latency: a request present at edge N gives mem strobes asserted from cycle N+1.
  - If d_read and d_write are both high at grant, the op is a write; d_read is ignored.
  - The strobes are held until mem_resp.
  - In the cycle mem_resp = 1:
    - The winner's resp = 1, combinationally from mem_resp.
    - The winner's rdata = mem_rdata. rdata is 0 on a write.
    - The loser's resp stays 0.
    - At that edge: last_served is updated, the state goes to RECOVER, and the strobes drop.
  - A requester that deasserts its request mid-service does not abort the transaction; it completes and its resp pulse is still issued.
- RECOVER:
  - One cycle with no strobes and no resp. This lets the served cache deassert its request, so a stale request is never re-granted.
  - Goes to IDLE unconditionally. An arbitration hole of 1 cycle is the required cost.
- Fairness:
  - Under continuous contention the grants strictly alternate.
  - Neither side waits more than one other transaction plus 2 cycles (RECOVER and IDLE).
- rdata outputs are combinational pass-throughs in the resp cycle only; they are 0 otherwise. Callers latch on resp.
- mem_resp outside SERVE_* is ignored.

Test Plan:
- Reset then i_read=1, i_address=16'h0040 alone:
  - mem_read=1 and mem_address=0x0040 from the next cycle.
  - mem_resp with mem_rdata=128'hA5... gives i_resp=1 and i_rdata=A5... in the same cycle, with d_resp=0.
  - Strobes are 0 during RECOVER.
- After reset, i_read and d_write (d_address=0x1230, d_wdata=0xDEAD...) are raised together:
  - D is granted first, with mem_write=1 and mem_wdata=0xDEAD...
  - After d_resp, RECOVER and IDLE, I is granted.
  - conflict_count = 1.
- Both sides request continuously for 6 transactions:
  - Grant order is D,I,D,I,D,I.
  - conflict_count = 6.
  - No cycle has mem_read and mem_write both set.
- After grant, change d_address to 0xFFFE and drop d_read before mem_resp:
  - mem_address stays at the latched value.
  - d_resp still pulses once.
- Assert reset during SERVE_D with mem_write high:
  - All outputs are 0 in the same cycle.
  - A later mem_resp=1 produces no i_resp or d_resp.
- With CNT_WIDTH=4, force 20 contention events:
  - conflict_count saturates at 15 and does not wrap.
